// File: rtl/exec_decode_stage.sv
// Decode-and-execute stage of the 8-bit CPU: opcode decode, operand-B selection, ALU.
// Every result is registered, so downstream stages see the values one cycle later.
module exec_decode_stage (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BUSYWAIT,
    input  logic [31:0] INSTRUCTION,
    input  logic [7:0]  REGOUT1,
    input  logic [7:0]  REGOUT2,
    output logic [7:0]  ALURESULT,
    output logic        ZERO,
    output logic [2:0]  ALUOP,
    output logic        WRITEENABLE,
    output logic        WRITEMUX_SEL,
    output logic        BRANCHENABLE,
    output logic        JUMPENABLE,
    output logic        READ,
    output logic        WRITE
);

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    logic [7:0] opcode;
    logic [7:0] imm;
    logic       unused_instr_bits;

    assign opcode            = INSTRUCTION[31:24];
    assign imm               = INSTRUCTION[7:0];
    assign unused_instr_bits = ^INSTRUCTION[23:8];

    // Decoded control word for the current instruction
    logic [2:0] aluop_next;
    logic       we_next;
    logic       twos_sel;
    logic       imm_sel;
    logic       br_next;
    logic       j_next;
    logic       wmux_next;
    logic       rd_next;
    logic       wr_next;

    always_comb begin
        aluop_next = ALU_FWD;
        we_next    = 1'b0;
        twos_sel   = 1'b0;
        imm_sel    = 1'b0;
        br_next    = 1'b0;
        j_next     = 1'b0;
        wmux_next  = 1'b0;
        rd_next    = 1'b0;
        wr_next    = 1'b0;
        case (opcode)
            8'h00: begin                        // loadi
                we_next = 1'b1;
                imm_sel = 1'b1;
            end
            8'h01: begin                        // mov
                we_next = 1'b1;
            end
            8'h02: begin                        // add
                aluop_next = ALU_ADD;
                we_next    = 1'b1;
            end
            8'h03: begin                        // sub
                aluop_next = ALU_ADD;
                we_next    = 1'b1;
                twos_sel   = 1'b1;
            end
            8'h04: begin                        // and
                aluop_next = ALU_AND;
                we_next    = 1'b1;
            end
            8'h05: begin                        // or
                aluop_next = ALU_OR;
                we_next    = 1'b1;
            end
            8'h06: begin                        // j
                j_next = 1'b1;
            end
            8'h07: begin                        // beq: subtract and test ZERO
                aluop_next = ALU_ADD;
                twos_sel   = 1'b1;
                br_next    = 1'b1;
            end
            8'h08: begin                        // lwd
                we_next   = 1'b1;
                wmux_next = 1'b1;
                rd_next   = 1'b1;
            end
            8'h09: begin                        // lwi
                we_next   = 1'b1;
                imm_sel   = 1'b1;
                wmux_next = 1'b1;
                rd_next   = 1'b1;
            end
            8'h0A: begin                        // swd
                wr_next = 1'b1;
            end
            8'h0B: begin                        // swi
                imm_sel = 1'b1;
                wr_next = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand B: register, its negation, or the immediate
    logic [7:0] twos_val;
    logic [7:0] operand_b;

    assign twos_val  = twos_sel ? (~REGOUT2 + 8'd1) : REGOUT2;
    assign operand_b = imm_sel ? imm : twos_val;

    logic [7:0] sum_val;
    logic [7:0] and_val;
    logic [7:0] or_val;

    assign sum_val = REGOUT1 + operand_b;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_logic_bits
            assign and_val[gi] = REGOUT1[gi] & operand_b[gi];
            assign or_val[gi]  = REGOUT1[gi] | operand_b[gi];
        end
    endgenerate

    logic [7:0] result_next;
    logic       zero_next;

    always_comb begin
        result_next = 8'h00;
        case (aluop_next)
            ALU_FWD: result_next = operand_b;
            ALU_ADD: result_next = sum_val;
            ALU_AND: result_next = and_val;
            ALU_OR:  result_next = or_val;
            default: result_next = 8'h00;
        endcase
        zero_next = (result_next == 8'h00);
    end

    logic [7:0] result_reg;
    logic       zero_reg;
    logic [2:0] aluop_reg;
    logic       we_reg;
    logic       wmux_reg;
    logic       br_reg;
    logic       j_reg;
    logic       rd_reg;
    logic       wr_reg;

    // Reset forces ZERO low rather than reporting a zero result
    always_ff @(posedge CLK) begin
        if (RESET) begin
            result_reg <= 8'h00;
            zero_reg   <= 1'b0;
            aluop_reg  <= 3'b000;
            we_reg     <= 1'b0;
            wmux_reg   <= 1'b0;
            br_reg     <= 1'b0;
            j_reg      <= 1'b0;
            rd_reg     <= 1'b0;
            wr_reg     <= 1'b0;
        end else if (!BUSYWAIT) begin
            result_reg <= result_next;
            zero_reg   <= zero_next;
            aluop_reg  <= aluop_next;
            we_reg     <= we_next;
            wmux_reg   <= wmux_next;
            br_reg     <= br_next;
            j_reg      <= j_next;
            rd_reg     <= rd_next;
            wr_reg     <= wr_next;
        end
    end

    assign ALURESULT    = result_reg;
    assign ZERO         = zero_reg;
    assign ALUOP        = aluop_reg;
    assign WRITEENABLE  = we_reg;
    assign WRITEMUX_SEL = wmux_reg;
    assign BRANCHENABLE = br_reg;
    assign JUMPENABLE   = j_reg;
    assign READ         = rd_reg;
    assign WRITE        = wr_reg;

endmodule

// File: tb/tb_exec_decode_stage.sv
// Directed-vector bench for exec_decode_stage with a queue-based scoreboard:
// the driver pushes hand-computed expectations, a monitor checks after each edge.
module tb_exec_decode_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        BUSYWAIT;
    logic [31:0] INSTRUCTION;
    logic [7:0]  REGOUT1;
    logic [7:0]  REGOUT2;
    logic [7:0]  ALURESULT;
    logic        ZERO;
    logic [2:0]  ALUOP;
    logic        WRITEENABLE;
    logic        WRITEMUX_SEL;
    logic        BRANCHENABLE;
    logic        JUMPENABLE;
    logic        READ;
    logic        WRITE;

    exec_decode_stage dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .BUSYWAIT     (BUSYWAIT),
        .INSTRUCTION  (INSTRUCTION),
        .REGOUT1      (REGOUT1),
        .REGOUT2      (REGOUT2),
        .ALURESULT    (ALURESULT),
        .ZERO         (ZERO),
        .ALUOP        (ALUOP),
        .WRITEENABLE  (WRITEENABLE),
        .WRITEMUX_SEL (WRITEMUX_SEL),
        .BRANCHENABLE (BRANCHENABLE),
        .JUMPENABLE   (JUMPENABLE),
        .READ         (READ),
        .WRITE        (WRITE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        rst;
        logic        busy;
        logic [7:0]  op;
        logic [7:0]  imm;
        logic [7:0]  r1;
        logic [7:0]  r2;
        logic [7:0]  res;
        logic        zero;
        logic [2:0]  aluop;
        logic        we;
        logic        wmux;
        logic        br;
        logic        j;
        logic        rd;
        logic        wr;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vectors = 0;
    int   n_miscompares = 0;

    task automatic add_vec(input logic rst, input logic busy, input logic [7:0] op,
                           input logic [7:0] imm, input logic [7:0] r1, input logic [7:0] r2,
                           input logic [7:0] res, input logic zero, input logic [2:0] aluop,
                           input logic we, input logic wmux, input logic br, input logic j,
                           input logic rd, input logic wr);
        vec_t v;
        v = '{rst, busy, op, imm, r1, r2, res, zero, aluop, we, wmux, br, j, rd, wr};
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        RESET       = v.rst;
        BUSYWAIT    = v.busy;
        INSTRUCTION = {v.op, 16'h5A5A, v.imm};
        REGOUT1     = v.r1;
        REGOUT2     = v.r2;
        exp_q.push_back(v);
    endtask

    // Monitor: one output set per rising edge, checked 1 time unit later
    initial begin
        vec_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vectors++;
                if ({ALURESULT, ZERO, ALUOP, WRITEENABLE, WRITEMUX_SEL, BRANCHENABLE,
                     JUMPENABLE, READ, WRITE} !==
                    {e.res, e.zero, e.aluop, e.we, e.wmux, e.br, e.j, e.rd, e.wr}) begin
                    n_miscompares++;
                    $display("FAIL vec%0d op=%02h rst=%0b busy=%0b: got res=%02h z=%0b aluop=%0d we=%0b wmux=%0b br=%0b j=%0b rd=%0b wr=%0b, want res=%02h z=%0b aluop=%0d we=%0b wmux=%0b br=%0b j=%0b rd=%0b wr=%0b",
                             n_vectors - 1, e.op, e.rst, e.busy,
                             ALURESULT, ZERO, ALUOP, WRITEENABLE, WRITEMUX_SEL,
                             BRANCHENABLE, JUMPENABLE, READ, WRITE,
                             e.res, e.zero, e.aluop, e.we, e.wmux, e.br, e.j, e.rd, e.wr);
                end else begin
                    $display("vec%0d op=%02h rst=%0b busy=%0b r1=%02h r2=%02h imm=%02h -> res=%02h z=%0b aluop=%0d ok",
                             n_vectors - 1, e.op, e.rst, e.busy, e.r1, e.r2, e.imm,
                             ALURESULT, ZERO, ALUOP);
                end
            end
        end
    end

    initial begin
        //      rst busy op     imm    r1     r2     res    z  aluop  we wm br j  rd wr
        add_vec(1, 0, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 0, 3'd0, 0, 0, 0, 0, 0, 0); // reset
        add_vec(0, 0, 8'h00, 8'h2A, 8'h00, 8'h00, 8'h2A, 0, 3'd0, 1, 0, 0, 0, 0, 0); // loadi
        add_vec(0, 0, 8'h02, 8'h00, 8'hF0, 8'h20, 8'h10, 0, 3'd1, 1, 0, 0, 0, 0, 0); // add carry
        add_vec(0, 0, 8'h03, 8'h00, 8'h05, 8'h07, 8'hFE, 0, 3'd1, 1, 0, 0, 0, 0, 0); // sub
        add_vec(0, 0, 8'h07, 8'h00, 8'h33, 8'h33, 8'h00, 1, 3'd1, 0, 0, 1, 0, 0, 0); // beq eq
        add_vec(0, 0, 8'h07, 8'h00, 8'h34, 8'h33, 8'h01, 0, 3'd1, 0, 0, 1, 0, 0, 0); // beq ne
        add_vec(0, 0, 8'h04, 8'h00, 8'hCC, 8'hAA, 8'h88, 0, 3'd2, 1, 0, 0, 0, 0, 0); // and
        add_vec(0, 0, 8'h05, 8'h00, 8'hCC, 8'hAA, 8'hEE, 0, 3'd3, 1, 0, 0, 0, 0, 0); // or
        add_vec(0, 0, 8'h06, 8'h00, 8'h11, 8'h22, 8'h22, 0, 3'd0, 0, 0, 0, 1, 0, 0); // j
        add_vec(0, 0, 8'hFF, 8'h99, 8'h11, 8'h05, 8'h05, 0, 3'd0, 0, 0, 0, 0, 0, 0); // no-op
        add_vec(0, 0, 8'h09, 8'h10, 8'h77, 8'h66, 8'h10, 0, 3'd0, 1, 1, 0, 0, 1, 0); // lwi
        add_vec(0, 1, 8'h02, 8'h00, 8'h01, 8'h01, 8'h10, 0, 3'd0, 1, 1, 0, 0, 1, 0); // stall
        add_vec(0, 1, 8'h04, 8'h00, 8'h01, 8'h01, 8'h10, 0, 3'd0, 1, 1, 0, 0, 1, 0); // stall
        add_vec(0, 1, 8'h06, 8'h00, 8'h01, 8'h01, 8'h10, 0, 3'd0, 1, 1, 0, 0, 1, 0); // stall
        add_vec(0, 0, 8'h02, 8'h00, 8'h01, 8'h01, 8'h02, 0, 3'd1, 1, 0, 0, 0, 0, 0); // resume
        add_vec(0, 0, 8'h0A, 8'h00, 8'h55, 8'h07, 8'h07, 0, 3'd0, 0, 0, 0, 0, 0, 1); // swd
        add_vec(0, 1, 8'h05, 8'h00, 8'h0F, 8'hF0, 8'h07, 0, 3'd0, 0, 0, 0, 0, 0, 1); // stall
        add_vec(1, 1, 8'h05, 8'h00, 8'h0F, 8'hF0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 0, 0); // rst in stall
        add_vec(0, 0, 8'h01, 8'h00, 8'h12, 8'h00, 8'h00, 1, 3'd0, 1, 0, 0, 0, 0, 0); // mov zero
        add_vec(0, 0, 8'h08, 8'h00, 8'h12, 8'h80, 8'h80, 0, 3'd0, 1, 1, 0, 0, 1, 0); // lwd
        add_vec(0, 0, 8'h0B, 8'h44, 8'h12, 8'h80, 8'h44, 0, 3'd0, 0, 0, 0, 0, 0, 1); // swi
        add_vec(0, 0, 8'h0C, 8'h00, 8'h12, 8'h00, 8'h00, 1, 3'd0, 0, 0, 0, 0, 0, 0); // undefined

        drive(vecs[0]);
        for (int i = 1; i < vecs.size(); i++) begin
            @(negedge CLK);
            drive(vecs[i]);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge CLK);
        if (exp_q.size() > 0) begin
            n_miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        if (n_vectors != vecs.size()) begin
            n_miscompares++;
            $display("FAIL count: checked %0d vectors, want %0d", n_vectors, vecs.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/exec_decode_stage.md
# exec_decode_stage

Decode-and-execute stage of the 8-bit single-issue CPU. Decodes the 32-bit instruction word into control signals and selects the ALU second operand: register, its two's complement, or the 8-bit immediate. Computes the 8-bit ALU result and zero flag. All results are captured in an output register, so the stage presents them to the register-file write-back, memory and PC logic one cycle later.

## Interface
- No parameters.
- CLK  input  1  system clock; all state changes on its rising edge.
- RESET  input  1  synchronous, active-high reset; clears every output register.
- BUSYWAIT  input  1  memory stall; when high, output registers hold their value.
- INSTRUCTION  input  32  instruction word: [31:24] opcode, [7:0] immediate.
- REGOUT1  input  8  register-file read port 1, used as ALU operand A.
- REGOUT2  input  8  register-file read port 2, the candidate for ALU operand B.
- ALURESULT  output  8  registered ALU result.
- ZERO  output  1  registered flag; 1 when the result is 0x00.
- ALUOP  output  3  registered ALU operation code.
- WRITEENABLE  output  1  registered register-file write enable.
- WRITEMUX_SEL  output  1  registered write-back source: 0 = ALU, 1 = memory data.
- BRANCHENABLE, JUMPENABLE  output  1 each  registered branch and jump requests.
- READ, WRITE  output  1 each  registered data-memory read and write requests.

## Operation
- Combinational decode from the opcode. The columns below are ALUOP / WE / TWOS / IMM / BR / J / WMUX / RD / WR.
  - 0x00 loadi: 000/1/0/1/0/0/0/0/0
  - 0x01 mov: 000/1/0/0/0/0/0/0/0
  - 0x02 add: 001/1/0/0/0/0/0/0/0
  - 0x03 sub: 001/1/1/0/0/0/0/0/0
  - 0x04 and: 010/1/0/0/0/0/0/0/0
  - 0x05 or: 011/1/0/0/0/0/0/0/0
  - 0x06 j: 000/0/0/0/0/1/0/0/0
  - 0x07 beq: 001/0/1/0/1/0/0/0/0
  - 0x08 lwd: 000/1/0/0/0/0/1/1/0
  - 0x09 lwi: 000/1/0/1/0/0/1/1/0
  - 0x0A swd: 000/0/0/0/0/0/0/0/1
  - 0x0B swi: 000/0/0/1/0/0/0/0/1
  - Any other opcode is a no-op: all control signals 0, ALUOP 000.
- Operand B selection:
  - TWOS=1 gives twos = (~REGOUT2 + 1) mod 256; otherwise twos = REGOUT2.
  - IMM=1 gives B = INSTRUCTION[7:0]; otherwise B = twos.
- ALU operations (A = REGOUT1), all mod 256:
  - 000 FORWARD: B
  - 001 ADD: A + B, carry discarded
  - 010 AND: A & B
  - 011 OR: A | B
  - 100–111: 0x00
- ZERO = (ALU result == 0x00). It is meaningful for every opcode and is consumed by beq.
- For load and store instructions, ALURESULT carries the memory address, which is operand B forwarded.

## Timing
- Decode, operand selection and the ALU are combinational within the cycle.
- Registered outputs have 1-cycle latency: an instruction applied before rising edge N appears on the outputs after edge N.
- Priority at a rising edge:
  - RESET=1: all outputs 0. ALURESULT = 0x00, ALUOP = 000, and ZERO = 0 (ZERO is forced to 0, not recomputed).
  - Else BUSYWAIT=1: hold all outputs. READ/WRITE stay asserted through the whole stall.
  - Else capture the new decode and ALU values.
- Reset mid-stall: RESET wins and clears READ/WRITE on that edge.
- Outputs never change between clock edges.

## Test plan
- RESET=1 for one edge → all outputs 0, including ZERO=0; then loadi with imm 0x2A → next edge ALURESULT=0x2A, WE=1, ZERO=0.
- add, REGOUT1=0xF0, REGOUT2=0x20 → ALURESULT=0x10, ALUOP=001 (carry dropped); sub, 0x05−0x07 → 0xFE.
- beq, REGOUT1=REGOUT2=0x33 → ALURESULT=0x00, ZERO=1, BRANCHENABLE=1, WE=0; with 0x34 vs 0x33 → ZERO=0.
- and 0xCC & 0xAA → 0x88; or → 0xEE; j → JUMPENABLE=1 and all other enables 0; opcode 0xFF → all controls 0.
- lwi imm 0x10 → READ=1, WMUX=1, ALURESULT=0x10. Then raise BUSYWAIT for 3 edges while changing INSTRUCTION → outputs frozen; drop BUSYWAIT → new instruction captured on the next edge.
- swd with REGOUT2=0x07 → WRITE=1, WE=0, ALURESULT=0x07. Assert RESET during a BUSYWAIT stall → WRITE=0 after that edge.
